// File: rtl/mmio_pkg.sv
// mmio_pkg
//   Shared constants for the memory-mapped transmit/timer responder:
//   register select codes (address bits [4:2]), STATUS bit positions,
//   the default window base and the COMPARE reset value.
package mmio_pkg;

  // Register select codes, taken from address bits [4:2].
  localparam logic [2:0] REG_TXDATA  = 3'd0;
  localparam logic [2:0] REG_STATUS  = 3'd1;
  localparam logic [2:0] REG_TIMER   = 3'd2;
  localparam logic [2:0] REG_COMPARE = 3'd3;

  // STATUS bit positions.
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVERFLOW  = 2;
  localparam int ST_MATCH     = 3;
  localparam int ST_COUNT_LSB = 4;

  localparam logic [31:0] DEFAULT_BASE = 32'hFFFF_FF00;
  localparam logic [31:0] COMPARE_RST  = 32'hFFFF_FFFF;

endpackage

// File: rtl/mmio_tx_timer_tx_fifo.sv
// tx_fifo
//   Byte-wide circular FIFO feeding the transmit consumer.
//   A push is accepted when the FIFO is not full, or when a pop happens
//   in the same cycle; a pop is accepted only when the FIFO is not empty.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push       push request, dataIn is stored when accepted
//   pop        pop request, head advances when accepted
//   head       head entry, zero when empty
//   empty/full occupancy flags
//   count      occupancy, 0..DEPTH
module tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty  = (count == '0);
  assign full   = (count == CW'(DEPTH));
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = empty ? '0 : mem[rdPtr];

  // NOTE: the storage array has no reset; occupancy is tracked by count and
  // pointers, and head is masked while empty, so stale entries never leak.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= dataIn;
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= (wrPtr == AW'(DEPTH - 1)) ? '0 : wrPtr + AW'(1);
      if (doPop)  rdPtr <= (rdPtr == AW'(DEPTH - 1)) ? '0 : rdPtr + AW'(1);
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_tx_timer.sv
// mmio_tx_timer
//   Memory-stage MMIO responder decoding a 32-byte window at BASE:
//     0x00 TXDATA  write pushes WD[7:0] into the transmit FIFO, reads 0
//     0x04 STATUS  {count[7:4], match, overflow, full, empty}; W1C bits 2,3
//     0x08 TIMER   free-running counter, writes load it
//     0x0C COMPARE compare value; TIMER == COMPARE sets match pending
//   Timer, compare, match pending and irq exist only when MMIO_TIMER_EN is
//   defined; otherwise 0x08/0x0C read 0, STATUS[3] reads 0, irq is 0.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   WE, A, WD         memory-stage write enable, byte address, store data
//   RD, hit           combinational load data and window decode
//   txData, txValid   FIFO head byte (0 when empty) and not-empty
//   txReady           consumer accepts the head byte
//   irq               match pending
module mmio_tx_timer
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = DEFAULT_BASE,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        hit,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [2:0]    regSel;
  logic          wrEn;
  logic          pushReq;
  logic          popReq;
  logic          statusWr;
  logic          fifoEmpty;
  logic          fifoFull;
  logic [CW-1:0] fifoCount;
  logic          overflow;
  logic          overflowSet;
  logic          matchPending;
  logic [31:0]   status;
  logic          unusedBits;

  assign hit      = (A[31:5] == BASE[31:5]);
  assign regSel   = A[4:2];
  assign wrEn     = WE && hit;
  assign pushReq  = wrEn && (regSel == REG_TXDATA);
  assign statusWr = wrEn && (regSel == REG_STATUS);
  assign popReq   = txValid && txReady;

  // Address bits [1:0] never select anything; upper store bits are only
  // meaningful for the timer registers.
  assign unusedBits = &{1'b0, A[1:0], WD};

  tx_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (pushReq),
    .pop    (popReq),
    .dataIn (WD[7:0]),
    .head   (txData),
    .empty  (fifoEmpty),
    .full   (fifoFull),
    .count  (fifoCount)
  );

  assign txValid = !fifoEmpty;

  // A full-FIFO push is only lost when no pop frees a slot that same edge.
  assign overflowSet = pushReq && fifoFull && !popReq;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (overflowSet) begin
      overflow <= 1'b1;
    end else if (statusWr && WD[ST_OVERFLOW]) begin
      overflow <= 1'b0;
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer;
  logic [31:0] compare;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer        <= '0;
      compare      <= COMPARE_RST;
      matchPending <= 1'b0;
    end else begin
      if (wrEn && (regSel == REG_TIMER)) timer <= WD;
      else                               timer <= timer + 32'd1;

      if (wrEn && (regSel == REG_COMPARE)) compare <= WD;

      // Hardware set wins over a same-cycle W1C.
      if (timer == compare)                  matchPending <= 1'b1;
      else if (statusWr && WD[ST_MATCH])     matchPending <= 1'b0;
    end
  end
`else
  assign matchPending = 1'b0;
`endif

  assign irq = matchPending;

  always_comb begin
    status                        = '0;
    status[ST_EMPTY]              = fifoEmpty;
    status[ST_FULL]               = fifoFull;
    status[ST_OVERFLOW]           = overflow;
    status[ST_MATCH]              = matchPending;
    status[ST_COUNT_LSB +: 4]     = 4'(fifoCount);
  end

  // NOTE: RD gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    RD = '0;
    if (hit) begin
      case (regSel)
        REG_STATUS:  RD = status;
`ifdef MMIO_TIMER_EN
        REG_TIMER:   RD = timer;
        REG_COMPARE: RD = compare;
`endif
        default:     RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_tx_timer.sv
// tb_mmio_tx_timer
//   Directed bench for mmio_tx_timer (DEPTH = 8, default BASE). Inputs are
//   driven 1 ns after the rising edge; outputs are sampled before the next.
//   Timer scenarios follow the MMIO_TIMER_EN setting of the build.
module tb_mmio_tx_timer;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        WE;
  logic [31:0] A;
  logic [31:0] WD;
  logic [31:0] RD;
  logic        hit;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        irq;

  int vectors;
  int miscompares;

  mmio_tx_timer #(
    .BASE  (BASE),
    .DEPTH (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .WE      (WE),
    .A       (A),
    .WD      (WD),
    .RD      (RD),
    .hit     (hit),
    .txData  (txData),
    .txValid (txValid),
    .txReady (txReady),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busWrite(input logic [7:0] off, input logic [31:0] d);
    A  = BASE + 32'(off);
    WD = d;
    WE = 1'b1;
    tick();
    WE = 1'b0;
    WD = '0;
  endtask

  task automatic busRead(input logic [7:0] off, output logic [31:0] d);
    A  = BASE + 32'(off);
    WE = 1'b0;
    #1;
    d = RD;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    rst = 1'b0; WE = 1'b0; A = '0; WD = '0; txReady = 1'b0;
    #2;
    vectors++; if (txValid !== 1'b0) begin miscompares++; $display("FAIL reset_txValid got %0h want 0", txValid); end
    vectors++; if (txData !== 8'h00) begin miscompares++; $display("FAIL reset_txData got %0h want 0", txData); end
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %0h want 0", irq); end
    rst = 1'b1;
    tick();
    busRead(8'h04, d);
    vectors++; if (d !== 32'h1) begin miscompares++; $display("FAIL reset_status got %0h want 1", d); end
    busRead(8'h0C, d);
`ifdef MMIO_TIMER_EN
    vectors++; if (d !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_compare got %0h want ffffffff", d); end
`else
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_compare got %0h want 0", d); end
`endif
    vectors++; if (txValid !== 1'b0 || irq !== 1'b0) begin miscompares++; $display("FAIL reset_release got txValid=%0h irq=%0h want 0 0", txValid, irq); end
  endtask

  task automatic test_fifo_order();
    logic [31:0] d;
    busWrite(8'h00, 32'h0000_0041);
    vectors++; if (txValid !== 1'b1 || txData !== 8'h41) begin miscompares++; $display("FAIL first_push got valid=%0h data=%0h want 1 41", txValid, txData); end
    busWrite(8'h00, 32'hFFFF_FF42);
    busRead(8'h04, d);
    vectors++; if (d !== 32'h20) begin miscompares++; $display("FAIL two_status got %0h want 20", d); end
    busRead(8'h00, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL txdata_read got %0h want 0", d); end
    txReady = 1'b1;
    #1;
    vectors++; if (txData !== 8'h41) begin miscompares++; $display("FAIL order_0 got %0h want 41", txData); end
    tick();
    vectors++; if (txData !== 8'h42 || txValid !== 1'b1) begin miscompares++; $display("FAIL order_1 got valid=%0h data=%0h want 1 42", txValid, txData); end
    tick();
    txReady = 1'b0;
    vectors++; if (txValid !== 1'b0 || txData !== 8'h00) begin miscompares++; $display("FAIL drained got valid=%0h data=%0h want 0 0", txValid, txData); end
    busRead(8'h05, d);  // A[1:0] ignored
    vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL drained_status got %0h want 1", d); end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) busWrite(8'h00, 32'(8'h10 + i));
    busRead(8'h04, d);
    vectors++; if (d !== 32'h86) begin miscompares++; $display("FAIL ovf_status got %0h want 86", d); end
    busWrite(8'h04, 32'h4);
    busRead(8'h04, d);
    vectors++; if (d !== 32'h82) begin miscompares++; $display("FAIL ovf_clear got %0h want 82", d); end
    txReady = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (txData !== 8'(8'h10 + i) || txValid !== 1'b1) begin miscompares++; $display("FAIL ovf_drain_%0d got valid=%0h data=%0h want 1 %0h", i, txValid, txData, 8'(8'h10 + i)); end
      tick();
    end
    txReady = 1'b0;
    vectors++; if (txValid !== 1'b0) begin miscompares++; $display("FAIL ovf_ninth got valid=%0h want 0", txValid); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] d;
    for (int i = 0; i < 8; i++) busWrite(8'h00, 32'(8'h20 + i));
    txReady = 1'b1;
    busWrite(8'h00, 32'h28);
    txReady = 1'b0;
    busRead(8'h04, d);
    vectors++; if (d !== 32'h82) begin miscompares++; $display("FAIL pushpop_status got %0h want 82", d); end
    txReady = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      vectors++; if (txData !== 8'(8'h21 + i)) begin miscompares++; $display("FAIL pushpop_drain_%0d got %0h want %0h", i, txData, 8'(8'h21 + i)); end
      tick();
    end
    txReady = 1'b0;
    vectors++; if (txValid !== 1'b0) begin miscompares++; $display("FAIL pushpop_empty got %0h want 0", txValid); end
  endtask

  task automatic test_timer();
    logic [31:0] d;
`ifdef MMIO_TIMER_EN
    busWrite(8'h0C, 32'd15);
    busWrite(8'h08, 32'd10);
    busRead(8'h08, d);
    vectors++; if (d !== 32'd10 || irq !== 1'b0) begin miscompares++; $display("FAIL timer_load got %0d irq=%0h want 10 0", d, irq); end
    repeat (5) tick();
    busRead(8'h08, d);
    vectors++; if (d !== 32'd15 || irq !== 1'b0) begin miscompares++; $display("FAIL timer_equal got %0d irq=%0h want 15 0", d, irq); end
    tick();
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL irq_rise got %0h want 1", irq); end
    repeat (3) tick();
    busRead(8'h04, d);
    vectors++; if (d !== 32'h09 || irq !== 1'b1) begin miscompares++; $display("FAIL irq_hold got status=%0h irq=%0h want 9 1", d, irq); end
    busWrite(8'h04, 32'h8);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %0h want 0", irq); end
    // W1C on a compare-equal cycle loses to the set.
    busWrite(8'h08, 32'd14);
    tick();
    busWrite(8'h04, 32'h8);
    vectors++; if (irq !== 1'b1) begin miscompares++; $display("FAIL set_beats_clear got %0h want 1", irq); end
    busWrite(8'h04, 32'h8);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear2 got %0h want 0", irq); end
    // TIMER write on a compare-equal cycle beats the increment.
    busWrite(8'h08, 32'd14);
    tick();
    busWrite(8'h08, 32'd100);
    busRead(8'h08, d);
    vectors++; if (d !== 32'd100 || irq !== 1'b1) begin miscompares++; $display("FAIL load_on_equal got %0d irq=%0h want 100 1", d, irq); end
    busWrite(8'h04, 32'h8);
    vectors++; if (irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear3 got %0h want 0", irq); end
`else
    busWrite(8'h08, 32'd5);
    busWrite(8'h0C, 32'd5);
    repeat (4) tick();
    busRead(8'h08, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL notimer_timer got %0h want 0", d); end
    busRead(8'h0C, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL notimer_compare got %0h want 0", d); end
    busRead(8'h04, d);
    vectors++; if (d !== 32'h01 || irq !== 1'b0) begin miscompares++; $display("FAIL notimer_status got %0h irq=%0h want 1 0", d, irq); end
`endif
  endtask

  task automatic test_miss();
    logic [31:0] d;
    A = 32'h0000_0100; WD = 32'h0000_0055; WE = 1'b1;
    #1;
    vectors++; if (hit !== 1'b0 || RD !== 32'h0) begin miscompares++; $display("FAIL miss_decode got hit=%0h RD=%0h want 0 0", hit, RD); end
    tick();
    WE = 1'b0;
    busRead(8'h04, d);
    vectors++; if (d !== 32'h01 || txValid !== 1'b0) begin miscompares++; $display("FAIL miss_nochange got status=%0h valid=%0h want 1 0", d, txValid); end
    busWrite(8'h14, 32'hFFFF_FFFF);
    busRead(8'h1C, d);
    vectors++; if (d !== 32'h0 || hit !== 1'b1) begin miscompares++; $display("FAIL unused_reg got RD=%0h hit=%0h want 0 1", d, hit); end
    busRead(8'h04, d);
    vectors++; if (d !== 32'h01) begin miscompares++; $display("FAIL unused_write got status=%0h want 1", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    busWrite(8'h00, 32'h77);
    busWrite(8'h00, 32'h78);
    rst = 1'b0;
    busRead(8'h04, d);
    vectors++; if (txValid !== 1'b0 || txData !== 8'h00 || irq !== 1'b0 || d !== 32'h01) begin miscompares++; $display("FAIL mid_reset got valid=%0h data=%0h irq=%0h status=%0h want 0 0 0 1", txValid, txData, irq, d); end
`ifdef MMIO_TIMER_EN
    busRead(8'h08, d);
    vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL mid_reset_timer got %0h want 0", d); end
`endif
    rst = 1'b1;
    tick();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_fifo_order();
    test_overflow();
    test_push_pop_full();
    test_timer();
    test_miss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mmio_tx_timer.md
# mmio_tx_timer

Memory-mapped I/O responder on the processor's memory-stage data bus, the target side of the load/store interface the pipeline drives toward data memory. It decodes a 32-byte window, buffers stored bytes in a transmit FIFO drained by an external valid/ready consumer, and provides a free-running timer with compare-match interrupt. The top level muxes `RD` into `readDataM` when `hit` is high and suppresses the data-memory write for hit addresses.

## Interface
- `BASE`, 32'hFFFF_FF00, window base; only `BASE[31:5]` is used.
- `DEPTH`, 8, FIFO entries; power of two, 2..8.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `WE` input 1: write enable from the memory stage (`memWriteM`).
- `A` input 32: byte address (`aluOutM`).
- `WD` input 32: store data (`writeDataM`).
- `RD` output 32: load data, combinational.
- `hit` output 1: `A[31:5] == BASE[31:5]`, combinational.
- `txData` output 8: FIFO head byte; 8'h00 when the FIFO is empty.
- `txValid` output 1: FIFO not empty.
- `txReady` input 1: consumer accepts the head byte.
- `irq` output 1: equals the match-pending bit.

## Operation
- Register select is `A[4:2]`; `A[1:0]` is ignored. An access is active only when `hit` is high. Writes require `WE && hit`.
- Offset 0x00 TXDATA:
  - Write pushes `WD[7:0]`.
  - Read returns 0.
- Offset 0x04 STATUS, read layout:
  - [0] empty.
  - [1] full.
  - [2] overflow, sticky.
  - [3] match pending.
  - [7:4] occupancy count, 0..DEPTH.
  - Remaining bits read 0.
  - Write is write-1-to-clear: `WD[2]` clears overflow and `WD[3]` clears match pending.
- Offset 0x08 TIMER:
  - Reads the current count.
  - A write loads `WD`.
  - Otherwise the count increments by 1 every cycle and wraps from 32'hFFFF_FFFF to 0.
- Offset 0x0C COMPARE: read/write, 32 bits.
- Offsets 0x10–0x1C read 0; writes to them are ignored.
- When not hit, `RD` = 0.
- Pop: occurs on a rising edge with `txValid && txReady`.
- Push acceptance:
  - Accepted when not full, or when a pop happens in the same cycle.
  - Push while full with no pop: the byte is dropped and overflow is set.
- Match: whenever the registered TIMER value equals COMPARE, match pending is set at the next edge.
- Precedence for same-cycle events:
  - A TIMER write beats the increment.
  - A hardware set beats a W1C clear, for both overflow and match.
  - Push and pop together on a non-empty FIFO leave the count unchanged.

## Timing
- Reset values:
  - `txValid` 0, `txData` 8'h00, `irq` 0.
  - Count 0, read/write pointers 0, overflow 0, pending 0.
  - TIMER 0, COMPARE 32'hFFFF_FFFF.
- `RD` and `hit` are zero-latency, matching the single-cycle data memory the stage expects. No wait states.
- Push on edge N into an empty FIFO: `txValid` is high and `txData` valid after edge N.
- Match: with TIMER == COMPARE during cycle N, `irq` is high after edge N+1 relative to the equality becoming visible, and stays high until cleared.
- A reset assertion mid-operation immediately empties the FIFO and returns every output to its reset value.

## Configuration
- `MMIO_TIMER_EN` defined: TIMER, COMPARE, match pending and `irq` operate as described.
- Undefined: no timer or compare storage is generated; offsets 0x08/0x0C read 0 and ignore writes; STATUS[3] reads 0; `irq` is tied 0. FIFO behaviour is unchanged.

## Structure
- Shared package `mmio_pkg`:
  - Register offset constants (TXDATA, STATUS, TIMER, COMPARE).
  - STATUS bit positions.
  - Default `BASE`.
  - COMPARE reset value.
- One sub-module, `tx_fifo`:
  - Parameterised width 8 and `DEPTH`.
  - Inputs: push, pop, data in.
  - Outputs: head, empty, full, count.
  - Pointer wrap at `DEPTH`.
- Address decode, STATUS assembly and the timer live in the top module.

## Test plan
- Reset release with `txReady`=0 -> `txValid`=0, `irq`=0; read 0x04 gives 0x1; read 0x0C gives 0xFFFF_FFFF.
- Write 0x41, 0x42 to `BASE`+0x00, then raise `txReady` -> `txData` shows 0x41 then 0x42 on consecutive cycles, then `txValid`=0 and STATUS[7:4] returns to 0.
- Push 9 bytes with `txReady`=0 and DEPTH=8 -> STATUS = 0x8_6 (full, overflow, count 8); the 9th byte is never emitted; writing 0x4 to STATUS clears bit 2.
- Fill FIFO, then push and pop in the same cycle -> byte accepted, count stays 8, overflow stays 0.
- Write TIMER=10 and COMPARE=15 -> `irq` rises once the count passes 15; a W1C of 0x8 drops it; writing TIMER on a compare-equal cycle shows the loaded value.
- Access `A`=0x0000_0100 with `WE`=1 -> `hit`=0, `RD`=0, no state change.
